// File: rtl/salamander_vram_cpu_arbiter.sv
// Slot arbiter sharing video RAM between the 68000 and the video fetch engine.
// The CPU gets one character-cycle slot per 8 (or every slot in vblank) and is acked after it.
//
// state   | meaning
// IDLE    | no CPU cycle pending, fetch engine owns the RAM
// WAIT    | CPU request seen, waiting for the next CPU slot edge
// ACCESS  | CPU owns the RAM mux for exactly one slot
// ACK     | DTACK asserted, waiting for the 68000 to drop AS
// RELEASE | one-MCLK guard before a new request may be taken
module salamander_vram_cpu_arbiter #(
    parameter logic [2:0] CPU_SLOT   = 3'd7,
    parameter bit         BLANK_FREE = 1'b1
) (
    input  logic       i_EMU_MCLK,
    input  logic       i_EMU_INITRST_n,
    input  logic       i_EMU_CLK6MPCEN_n,
    input  logic [2:0] i_HCOUNT,
    input  logic       i_VBLANK_n,
    input  logic       i_CPU_AS_n,
    input  logic       i_CPU_RW,
    input  logic       i_CPU_UDS_n,
    input  logic       i_CPU_LDS_n,
    input  logic       i_VRAMCS_n,
    output logic       o_CPU_GRANT,
    output logic [1:0] o_RAM_WE_n,
    output logic       o_RAM_RDLATCH,
    output logic       o_CPU_DTACK_n,
    output logic       o_BUSY
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_ACCESS,
        S_ACK,
        S_RELEASE
    } state_t;

    state_t     state_q;
    logic       grant_q;
    logic [1:0] we_n_q;
    logic       rdlatch_q;
    logic       dtack_n_q;
    logic       busy_q;
    logic       rw_q;

    logic slot_edge;
    logic cpu_slot;
    logic req;

    assign slot_edge = ~i_EMU_CLK6MPCEN_n;
    assign cpu_slot  = (i_HCOUNT == CPU_SLOT) | (BLANK_FREE & ~i_VBLANK_n);
    assign req       = ~i_CPU_AS_n & ~i_VRAMCS_n & (~i_CPU_UDS_n | ~i_CPU_LDS_n);

    always_ff @(posedge i_EMU_MCLK or negedge i_EMU_INITRST_n) begin
        if (!i_EMU_INITRST_n) begin
            state_q   <= S_IDLE;
            grant_q   <= 1'b0;
            we_n_q    <= 2'b11;
            rdlatch_q <= 1'b0;
            dtack_n_q <= 1'b1;
            busy_q    <= 1'b0;
            rw_q      <= 1'b1;
        end else begin
            rdlatch_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (req) begin
                        state_q <= S_WAIT;
                        busy_q  <= 1'b1;
                    end
                end
                S_WAIT: begin
                    if (i_CPU_AS_n) begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end else if (slot_edge && cpu_slot) begin
                        state_q <= S_ACCESS;
                        grant_q <= 1'b1;
                        rw_q    <= i_CPU_RW;
                        we_n_q  <= i_CPU_RW ? 2'b11 : {i_CPU_UDS_n, i_CPU_LDS_n};
                    end
                end
                S_ACCESS: begin
                    // The access always runs its full slot, even if AS has gone away.
                    if (slot_edge) begin
                        grant_q   <= 1'b0;
                        we_n_q    <= 2'b11;
                        rdlatch_q <= rw_q;
                        if (i_CPU_AS_n) begin
                            state_q <= S_IDLE;
                            busy_q  <= 1'b0;
                        end else begin
                            state_q   <= S_ACK;
                            dtack_n_q <= 1'b0;
                        end
                    end
                end
                S_ACK: begin
                    if (i_CPU_AS_n) begin
                        state_q   <= S_RELEASE;
                        dtack_n_q <= 1'b1;
                    end
                end
                S_RELEASE: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q   <= S_IDLE;
                    grant_q   <= 1'b0;
                    we_n_q    <= 2'b11;
                    dtack_n_q <= 1'b1;
                    busy_q    <= 1'b0;
                end
            endcase
        end
    end

    assign o_CPU_GRANT   = grant_q;
    assign o_RAM_WE_n    = we_n_q;
    assign o_RAM_RDLATCH = rdlatch_q;
    assign o_CPU_DTACK_n = dtack_n_q;
    assign o_BUSY        = busy_q;

endmodule
